lcd_bus_writer: RTL



---
 rtl/lcd_bus_writer_if.sv | 22 ++
 rtl/lcd_bus_writer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer_if.sv
// Upstream byte handshake plus LCD pin bundle for lcd_bus_writer; master = upstream side.
// A byte transfers when valid_i and ready_o are both high at a rising clock edge.
interface lcd_bus_writer_if;
  logic       valid_i;
  logic       rs_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       lcd_rs_o;
  logic       lcd_rw_o;
  logic       lcd_e_o;
  logic [7:0] lcd_db_o;

  modport master (
    output valid_i, rs_i, data_i,
    input  ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o
  );

  modport slave (
    input  valid_i, rs_i, data_i,
    output ready_o, lcd_rs_o, lcd_rw_o, lcd_e_o, lcd_db_o
  );
endinterface

// File: rtl/lcd_bus_writer.sv
// HD44780 write sequencer: busy T_AS+T_PW+T_H+exec cycles per byte (doubled strobe phases with
// LCD_BUS_4BIT_EN); ready only in IDLE, valid while busy is ignored; all outputs registered.
module lcd_bus_writer #(
  parameter int CLK_FREQ    = 125000000,
  parameter int T_AS        = int'((64'(CLK_FREQ) * 64'd40  + 64'd999999999) / 64'd1000000000),
  parameter int T_PW        = int'((64'(CLK_FREQ) * 64'd250 + 64'd999999999) / 64'd1000000000),
  parameter int T_H         = int'((64'(CLK_FREQ) * 64'd20  + 64'd999999999) / 64'd1000000000),
  parameter int T_EXEC      = int'((64'(CLK_FREQ) * 64'd40  + 64'd999999) / 64'd1000000),
  parameter int T_EXEC_LONG = int'((64'(CLK_FREQ) * 64'd164 + 64'd99999) / 64'd100000)
) (
  input logic           clk_i,
  input logic           rst_i,
  lcd_bus_writer_if.slave bus
);

`ifdef LCD_BUS_4BIT_EN
  localparam bit FOUR_BIT = 1'b1;
`else
  localparam bit FOUR_BIT = 1'b0;
`endif

  localparam int M1   = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int M2   = (M1 > T_H) ? M1 : T_H;
  localparam int M3   = (M2 > T_EXEC) ? M2 : T_EXEC;
  localparam int MAXT = (M3 > T_EXEC_LONG) ? M3 : T_EXEC_LONG;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          rs_q, rs_d;
  logic [7:0]    dat_q, dat_d;
  logic          nib_q, nib_d;
  logic          ready_q, ready_d;
  logic          e_q, e_d;
  logic          lrs_q;
  logic [7:0]    db_q, db_d;
  logic          is_long;

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  assign is_long = !rs_q && (dat_q == 8'h01 || dat_q == 8'h02 || dat_q == 8'h03);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    rs_d    = rs_q;
    dat_d   = dat_q;
    nib_d   = nib_q;
    case (state)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          state_d = SETUP;
          cnt_d   = CW'(T_AS - 1);
          rs_d    = bus.rs_i;
          dat_d   = bus.data_i;
          nib_d   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_d = PULSE;
          cnt_d   = CW'(T_PW - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          state_d = HOLD;
          cnt_d   = CW'(T_H - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          if (FOUR_BIT && !nib_q) begin
            state_d = SETUP;
            cnt_d   = CW'(T_AS - 1);
            nib_d   = 1'b1;
          end else begin
            state_d = EXEC;
            cnt_d   = is_long ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
          end
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      EXEC: begin
        if (cnt == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so pins line up with the state itself.
    ready_d = (state_d == IDLE);
    e_d     = (state_d == PULSE);
    if (FOUR_BIT) begin
      db_d = nib_d ? {dat_d[3:0], 4'h0} : {dat_d[7:4], 4'h0};
    end else begin
      db_d = dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= '0;
      rs_q    <= 1'b0;
      dat_q   <= 8'h00;
      nib_q   <= 1'b0;
      ready_q <= 1'b0;
      e_q     <= 1'b0;
      lrs_q   <= 1'b0;
      db_q    <= 8'h00;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
      nib_q   <= nib_d;
      ready_q <= ready_d;
      e_q     <= e_d;
      lrs_q   <= rs_d;
      db_q    <= db_d;
    end
  end

  assign bus.ready_o  = ready_q;
  assign bus.lcd_e_o  = e_q;
  assign bus.lcd_rs_o = lrs_q;
  assign bus.lcd_db_o = db_q;
  assign bus.lcd_rw_o = 1'b0;

endmodule
